// File: rtl/rx_capture_buffer_pkg.sv
// rx_capture_pkg: shared FSM state type and default sizing for rx_capture_buffer.
package rx_capture_pkg;
  localparam int DEPTH_DEF = 1024;
  localparam int DW_DEF = 16;
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_READOUT} state_t;
endpackage

// File: rtl/rx_capture_buffer_sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_re/i_raddr read request;
// o_rdata read data, valid the cycle after i_re and held until the next read.
module sdp_ram #(
  parameter int AW = 10,
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [2**AW];
  logic [W-1:0] r_rdata;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/rx_capture_buffer.sv
// rx_capture_buffer: captures decimated I/Q pairs during an armed receive window, then streams them out.
// Ports: clk_8x clock; rst_n sync active-low reset; arm capture request;
// rx receive window; in_valid/data_in_i/data_in_q sample input;
// rd_ready/rd_valid/rd_data/rd_last readout stream ({I,Q});
// sample_count stored samples; overflow sticky full-drop flag; busy not IDLE.
module rx_capture_buffer
  import rx_capture_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                   clk_8x,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   rx,
  input  logic                   in_valid,
  input  logic [DW-1:0]          data_in_i,
  input  logic [DW-1:0]          data_in_q,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [2*DW-1:0]        rd_data,
  output logic                   rd_last,
  output logic [$clog2(DEPTH):0] sample_count,
  output logic                   overflow,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  state_t r_state, w_next;
  logic [CW-1:0] r_count, r_raddr;
  logic r_ov, r_s1_v, r_s1_last, r_rd_valid, r_rd_last, w_busy;
  logic [2*DW-1:0] r_rd_data, w_rdata;
  logic w_full, w_win, w_we, w_xfer, w_s2_en, w_s1_en, w_re;
  // Write window covers the ARMED cycle where rx rises, so that strobe becomes sample 0.
  assign w_full = r_count == FULL;
  assign w_win = rx && (r_state == S_ARMED || r_state == S_CAPTURE);
  assign w_we = w_win && in_valid && !w_full;
  // Two-stage read pipeline (RAM output, output register); each stage advances when the one after it can accept.
  assign w_xfer = r_rd_valid && rd_ready;
  assign w_s2_en = !r_rd_valid || rd_ready;
  assign w_s1_en = !r_s1_v || w_s2_en;
  assign w_re = r_state == S_READOUT && r_raddr < r_count && w_s1_en;
  always_ff @(posedge clk_8x) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (arm) w_next = S_ARMED;
      S_ARMED:   if (rx) w_next = S_CAPTURE;
      S_CAPTURE: if (!rx) w_next = r_count != '0 ? S_READOUT : S_IDLE;
      S_READOUT: if (w_xfer && r_rd_last) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end
  always_comb begin
    w_busy = r_state != S_IDLE;
  end
  always_ff @(posedge clk_8x) begin
    if (!rst_n) begin
      r_count <= '0;
      r_raddr <= '0;
      r_ov <= 1'b0;
      r_s1_v <= 1'b0;
      r_s1_last <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (r_state == S_IDLE && arm) begin
        r_count <= '0;
        r_raddr <= '0;
        r_ov <= 1'b0;
      end else begin
        if (w_we) r_count <= r_count + CW'(1);
        if (w_win && r_state == S_CAPTURE && in_valid && w_full) r_ov <= 1'b1;
        if (w_re) r_raddr <= r_raddr + CW'(1);
      end
      if (w_s1_en) begin
        r_s1_v <= w_re;
        r_s1_last <= r_raddr == r_count - CW'(1);
      end
      if (w_s2_en) begin
        r_rd_valid <= r_s1_v;
        r_rd_last <= r_s1_v && r_s1_last;
        r_rd_data <= w_rdata;
      end
    end
  end
  sdp_ram #(.AW(AW), .W(2*DW)) u_ram (
    .clk(clk_8x),
    .i_we(w_we),
    .i_waddr(r_count[AW-1:0]),
    .i_wdata({data_in_i, data_in_q}),
    .i_re(w_re),
    .i_raddr(r_raddr[AW-1:0]),
    .o_rdata(w_rdata)
  );
  assign rd_valid = r_rd_valid;
  assign rd_data = r_rd_data;
  assign rd_last = r_rd_last;
  assign sample_count = r_count;
  assign overflow = r_ov;
  assign busy = w_busy;
endmodule

// File: tb/tb_rx_capture_buffer.sv
// tb_rx_capture_buffer: directed self-checking bench for rx_capture_buffer (DEPTH 64 and DEPTH 16 instances).
module tb_rx_capture_buffer;
  logic clk_8x = 0, rst_n = 0, arm = 0, rx = 0, in_valid = 0, rd_ready = 0;
  logic [15:0] di = 0, dq = 0;
  logic rv0, rl0, ov0, b0, rv1, rl1, ov1, b1;
  logic [31:0] rd0, rd1;
  logic [6:0] sc0;
  logic [4:0] sc1;
  logic rv, rl, ov, b;
  logic [31:0] rd;
  logic [6:0] sc;
  bit sel = 0;
  int total = 0, bad = 0;
  rx_capture_buffer #(.DEPTH(64), .DW(16)) u0 (
    .clk_8x(clk_8x), .rst_n(rst_n), .arm(arm), .rx(rx), .in_valid(in_valid),
    .data_in_i(di), .data_in_q(dq), .rd_ready(rd_ready), .rd_valid(rv0),
    .rd_data(rd0), .rd_last(rl0), .sample_count(sc0), .overflow(ov0), .busy(b0)
  );
  rx_capture_buffer #(.DEPTH(16), .DW(16)) u1 (
    .clk_8x(clk_8x), .rst_n(rst_n), .arm(arm), .rx(rx), .in_valid(in_valid),
    .data_in_i(di), .data_in_q(dq), .rd_ready(rd_ready), .rd_valid(rv1),
    .rd_data(rd1), .rd_last(rl1), .sample_count(sc1), .overflow(ov1), .busy(b1)
  );
  always_comb begin
    rv = sel ? rv1 : rv0;
    rl = sel ? rl1 : rl0;
    ov = sel ? ov1 : ov0;
    b = sel ? b1 : b0;
    rd = sel ? rd1 : rd0;
    sc = sel ? {2'b00, sc1} : sc0;
  end
  always #5 clk_8x = ~clk_8x;
  task automatic tick();
    @(posedge clk_8x);
    #1;
  endtask
  function automatic logic [31:0] expw(int k);
    int n;
    n = -k;
    return {k[15:0], n[15:0]};
  endfunction
  task automatic capture(int n, int base);
    int nk;
    arm = 1;
    tick();
    arm = 0;
    for (int k = 0; k < n; k++) begin
      nk = -(base + k);
      rx = 1;
      in_valid = 1;
      di = 16'(base + k);
      dq = nk[15:0];
      tick();
    end
    rx = 0;
    in_valid = 1;
    di = 16'h7abc;
    dq = 16'h7abc;
    tick();
    in_valid = 0;
  endtask
  task automatic readout(int n, int base, bit rnd, bit noise);
    int got = 0, cyc = 0, first = -1, fx = 0, lx = 0;
    bit stall = 0;
    logic [31:0] pd = 0;
    logic pl = 0;
    while (got < n && cyc < 4000) begin
      if (rv && first < 0) first = cyc;
      if (stall) begin
        total++;
        if (rd !== pd || rl !== pl) begin
          bad++;
          $display("FAIL stall_hold word=%0d data=%h last=%b required data=%h last=%b", got, rd, rl, pd, pl);
        end
      end
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rv && rd_ready) begin
        total++;
        if (rd !== expw(base + got) || rl !== (got == n - 1)) begin
          bad++;
          $display("FAIL word k=%0d data=%h last=%b required data=%h last=%b", got, rd, rl, expw(base + got), got == n - 1);
        end
        if (got == 0) fx = cyc;
        lx = cyc;
        got++;
      end
      stall = rv && !rd_ready;
      pd = rd;
      pl = rl;
      arm = noise && got < n;
      in_valid = noise && got < n;
      rx = noise && got < n;
      tick();
      cyc++;
    end
    arm = 0;
    in_valid = 0;
    rx = 0;
    total++;
    if (got != n) begin
      bad++;
      $display("FAIL readout_count got=%0d required=%0d", got, n);
    end
    total++;
    if (first < 0 || first > 2) begin
      bad++;
      $display("FAIL rd_valid_latency cycles=%0d required<=2", first);
    end
    if (!rnd) begin
      total++;
      if (lx - fx != n - 1) begin
        bad++;
        $display("FAIL no_bubbles span=%0d required=%0d", lx - fx, n - 1);
      end
    end
    total++;
    if (rv !== 1'b0 || b !== 1'b0) begin
      bad++;
      $display("FAIL after_last rd_valid=%b busy=%b required 0 0", rv, b);
    end
    rd_ready = 0;
  endtask
  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    total++;
    if (rv0 !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b required=0", rv0); end
    total++;
    if (rl0 !== 1'b0) begin bad++; $display("FAIL reset_rd_last got=%b required=0", rl0); end
    total++;
    if (rd0 !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h required=0", rd0); end
    total++;
    if (sc0 !== 7'd0) begin bad++; $display("FAIL reset_count got=%0d required=0", sc0); end
    total++;
    if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b required=0", ov0); end
    total++;
    if (b0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b required=0", b0); end
    rst_n = 1;
    tick();
  endtask
  task automatic test_basic();
    sel = 0;
    capture(10, 0);
    total++;
    if (sc !== 7'd10 || ov !== 1'b0 || b !== 1'b1) begin
      bad++;
      $display("FAIL basic_status count=%0d ov=%b busy=%b required 10 0 1", sc, ov, b);
    end
    readout(10, 0, 0, 0);
  endtask
  task automatic test_overflow();
    sel = 1;
    capture(20, 0);
    total++;
    if (sc !== 7'd16 || ov !== 1'b1) begin
      bad++;
      $display("FAIL overflow_status count=%0d ov=%b required 16 1", sc, ov);
    end
    readout(16, 0, 0, 0);
    total++;
    if (sc !== 7'd16 || ov !== 1'b1) begin
      bad++;
      $display("FAIL overflow_hold count=%0d ov=%b required 16 1", sc, ov);
    end
    sel = 0;
    rd_ready = 1;
    for (int i = 0; i < 10; i++) tick();
    rd_ready = 0;
    total++;
    if (b0 !== 1'b0 || sc0 !== 7'd20) begin
      bad++;
      $display("FAIL deep_drain busy=%b count=%0d required 0 20", b0, sc0);
    end
  endtask
  task automatic test_random_ready();
    sel = 0;
    capture(64, 300);
    total++;
    if (sc !== 7'd64 || ov !== 1'b0) begin
      bad++;
      $display("FAIL random_status count=%0d ov=%b required 64 0", sc, ov);
    end
    readout(64, 300, 1, 0);
  endtask
  task automatic test_empty();
    sel = 0;
    arm = 1;
    tick();
    total++;
    if (b !== 1'b1 || sc !== 7'd0) begin
      bad++;
      $display("FAIL armed busy=%b count=%0d required 1 0", b, sc);
    end
    tick();
    arm = 0;
    rx = 1;
    in_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (b !== 1'b1) begin bad++; $display("FAIL empty_capture busy=%b required=1", b); end
    rx = 0;
    tick();
    total++;
    if (b !== 1'b0 || rv !== 1'b0 || sc !== 7'd0) begin
      bad++;
      $display("FAIL empty_exit busy=%b rd_valid=%b count=%0d required 0 0 0", b, rv, sc);
    end
    tick();
    tick();
    total++;
    if (rv !== 1'b0) begin bad++; $display("FAIL empty_no_valid rd_valid=%b required=0", rv); end
  endtask
  task automatic test_reset_readout();
    int got = 0, cyc = 0;
    sel = 0;
    capture(10, 0);
    rd_ready = 1;
    while (got < 5 && cyc < 50) begin
      if (rv) begin
        total++;
        if (rd !== expw(got)) begin
          bad++;
          $display("FAIL pre_reset_word k=%0d data=%h required=%h", got, rd, expw(got));
        end
        got++;
      end
      tick();
      cyc++;
    end
    total++;
    if (rv !== 1'b1 || rd !== expw(5)) begin
      bad++;
      $display("FAIL word5 rd_valid=%b data=%h required 1 %h", rv, rd, expw(5));
    end
    rst_n = 0;
    rd_ready = 0;
    tick();
    rst_n = 1;
    total++;
    if ({rv, rl, rd, sc, ov, b} !== 42'h0) begin
      bad++;
      $display("FAIL mid_readout_reset valid=%b last=%b data=%h count=%0d ov=%b busy=%b required all 0", rv, rl, rd, sc, ov, b);
    end
    capture(10, 200);
    total++;
    if (sc !== 7'd10) begin bad++; $display("FAIL post_reset_count got=%0d required=10", sc); end
    readout(10, 200, 0, 0);
  endtask
  task automatic test_idle_noise();
    sel = 0;
    rx = 1;
    in_valid = 1;
    di = 16'h1234;
    dq = 16'h5678;
    for (int i = 0; i < 4; i++) tick();
    rx = 0;
    in_valid = 0;
    total++;
    if (b !== 1'b0 || sc !== 7'd10 || rv !== 1'b0) begin
      bad++;
      $display("FAIL idle_strobes busy=%b count=%0d rd_valid=%b required 0 10 0", b, sc, rv);
    end
    capture(10, 50);
    readout(10, 50, 0, 1);
    total++;
    if (sc !== 7'd10 || ov !== 1'b0 || b !== 1'b0) begin
      bad++;
      $display("FAIL readout_noise count=%0d ov=%b busy=%b required 10 0 0", sc, ov, b);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_random_ready();
    test_empty();
    test_reset_readout();
    test_idle_noise();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
